// File: rtl/ts_pkg.sv
// Shared definitions for the tile/sprite DRAM fetch arbiter.
// State encoding equals the one-hot owner code, so owner status is the state itself.
package ts_pkg;

    localparam int unsigned DRAM_AW = 21;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_TM   = 2'b01;
    localparam logic [1:0] OWN_GR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TM   = 2'b01,
        ST_GR   = 2'b10
    } arb_state_t;

    // Word counter step that saturates at the burst cap.
    function automatic logic [7:0] wcnt_step(input logic [7:0] cnt, input logic [7:0] cap);
        return (cnt < cap) ? cnt + 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/ts_dram_arb.sv
// ts_dram_arb: two-requester arbiter (tilemap prefetch TM, renderer fetch GR)
// for the single DRAM video-fetch port, with per-grant burst cap.
// Optional feature: define TS_ARB_RR_EN for round-robin tie-break in IDLE;
// otherwise TM always wins a tie.
//
//  state   | meaning
//  --------+-----------------------------
//  ST_IDLE | no owner, dram_req low
//  ST_TM   | tilemap prefetcher owns port
//  ST_GR   | renderer fetch owns port
module ts_dram_arb
    import ts_pkg::*;
#(
    parameter int unsigned MAXBURST = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tm_req,
    input  logic [DRAM_AW-1:0] tm_addr,
    output logic               tm_next,
    input  logic               gr_req,
    input  logic [DRAM_AW-1:0] gr_addr,
    output logic               gr_next,
    output logic               dram_req,
    output logic [DRAM_AW-1:0] dram_addr,
    input  logic               dram_next,
    output logic [1:0]         owner
);

    localparam logic [7:0] C_MAXB = 8'(MAXBURST);

    arb_state_t         r_state;
    logic [7:0]         r_wcnt;

    logic               w_is_tm;
    logic               w_is_gr;
    logic               w_own_req;
    logic               w_tie_tm;
    logic               w_burst_end;
    logic               w_grant_tm;
    logic               w_grant_gr;
    logic [7:0]         w_wcnt_inc;

    assign w_is_tm = (r_state == ST_TM);
    assign w_is_gr = (r_state == ST_GR);

`ifdef TS_ARB_RR_EN
    // 1 when GR should win the next tie; cleared at reset and every line start.
    logic r_pref_gr;

    // Round-robin history: the requester just granted loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pref_gr <= 1'b0;
        end else if (start) begin
            r_pref_gr <= 1'b0;
        end else if (w_grant_tm) begin
            r_pref_gr <= 1'b1;
        end else if (w_grant_gr) begin
            r_pref_gr <= 1'b0;
        end
    end

    assign w_tie_tm = ~r_pref_gr;
`else
    assign w_tie_tm = 1'b1;
`endif

    // Owner's request and address mux, word counting and grant decisions.
    always_comb begin
        w_own_req   = 1'b0;
        w_wcnt_inc  = r_wcnt;
        w_burst_end = 1'b0;
        w_grant_tm  = 1'b0;
        w_grant_gr  = 1'b0;
        if (w_is_tm) begin
            w_own_req = tm_req;
        end else if (w_is_gr) begin
            w_own_req = gr_req;
        end
        // dram_next in IDLE is not counted: nobody owns the word.
        if (dram_next && (w_is_tm || w_is_gr)) begin
            w_wcnt_inc = wcnt_step(r_wcnt, C_MAXB);
        end
        // >= keeps handover possible after saturation while the other side was quiet.
        w_burst_end = dram_next && (({1'b0, r_wcnt} + 9'd1) >= {1'b0, C_MAXB});
        if (!start) begin
            if (r_state == ST_IDLE) begin
                w_grant_tm = tm_req && (!gr_req || w_tie_tm);
                w_grant_gr = gr_req && !(tm_req && w_tie_tm);
            end else if (w_is_tm) begin
                w_grant_gr = tm_req && w_burst_end && gr_req;
            end else if (w_is_gr) begin
                w_grant_tm = gr_req && w_burst_end && tm_req;
            end
        end
    end

    // Ownership FSM and burst word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 8'd0;
        end else if (start) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 8'd0;
        end else if (w_grant_tm) begin
            r_state <= ST_TM;
            r_wcnt  <= 8'd0;
        end else if (w_grant_gr) begin
            r_state <= ST_GR;
            r_wcnt  <= 8'd0;
        end else begin
            r_wcnt <= w_wcnt_inc;
            if ((w_is_tm || w_is_gr) && !w_own_req) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Port-side outputs: zero-latency routing from the owner state.
    always_comb begin
        dram_addr = '0;
        if (w_is_tm) begin
            dram_addr = tm_addr;
        end else if (w_is_gr) begin
            dram_addr = gr_addr;
        end
    end

    assign dram_req = w_own_req;
    assign tm_next  = dram_next & w_is_tm;
    assign gr_next  = dram_next & w_is_gr;
    assign owner    = r_state;

endmodule

// File: tb/tb_ts_dram_arb.sv
// Directed bench for ts_dram_arb (MAXBURST = 8); expectations follow
// TS_ARB_RR_EN when the bench is compiled with it.
module tb_ts_dram_arb;
    import ts_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               tm_req = 1'b0;
    logic [DRAM_AW-1:0] tm_addr = '0;
    logic               tm_next;
    logic               gr_req = 1'b0;
    logic [DRAM_AW-1:0] gr_addr = '0;
    logic               gr_next;
    logic               dram_req;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_next = 1'b0;
    logic [1:0]         owner;

    int n_checks = 0;
    int n_errors = 0;

    ts_dram_arb #(.MAXBURST(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tm_req(tm_req), .tm_addr(tm_addr), .tm_next(tm_next),
        .gr_req(gr_req), .gr_addr(gr_addr), .gr_next(gr_next),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_next(dram_next),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven here, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if (owner !== OWN_NONE || dram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold owner=%b dram_req=%b want 00/0", owner, dram_req);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            #1;
            n_checks++;
            if (dram_req !== 1'b0 || owner !== OWN_NONE || dram_addr !== 21'h0 ||
                tm_next !== 1'b0 || gr_next !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle cyc=%0d req=%b owner=%b addr=%h tmn=%b grn=%b want 0/00/0/0/0",
                         i, dram_req, owner, dram_addr, tm_next, gr_next);
            end
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        step();
        tm_req = 1'b1; tm_addr = 21'h1A000;
        #1;
        n_checks++;
        if (owner !== OWN_NONE || dram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL single_pre owner=%b dram_req=%b want 00/0", owner, dram_req);
        end
        step();
        dram_next = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if (owner !== OWN_TM || dram_req !== 1'b1 || dram_addr !== 21'h1A000 ||
                tm_next !== 1'b1 || gr_next !== 1'b0) begin
                n_errors++;
                $display("FAIL single_word i=%0d owner=%b req=%b addr=%h tmn=%b grn=%b want 01/1/1a000/1/0",
                         i, owner, dram_req, dram_addr, tm_next, gr_next);
            end
            if (tm_next === 1'b1) pulses++;
            step();
        end
        tm_req = 1'b0; dram_next = 1'b0;
        #1;
        n_checks++;
        if (pulses !== 16 || dut.r_wcnt !== 8'd8 || owner !== OWN_TM || dram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL single_end pulses=%0d wcnt=%0d owner=%b req=%b want 16/8/01/0",
                     pulses, dut.r_wcnt, owner, dram_req);
        end
        step();
        #1;
        n_checks++;
        if (owner !== OWN_NONE) begin
            n_errors++;
            $display("FAIL single_release owner=%b want 00", owner);
        end
    endtask

    task automatic test_burst_cap();
        logic [1:0] exp_tie;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        tm_req = 1'b1; gr_req = 1'b1;
        tm_addr = 21'h00100; gr_addr = 21'h1F000;
        dram_next = 1'b1;
        #1;
        n_checks++;
        if (owner !== OWN_NONE || tm_next !== 1'b0 || gr_next !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_next owner=%b tmn=%b grn=%b want 00/0/0", owner, tm_next, gr_next);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            #1;
            n_checks++;
            if (i < 8) begin
                if (owner !== OWN_TM || tm_next !== 1'b1 || gr_next !== 1'b0 || dram_addr !== 21'h00100) begin
                    n_errors++;
                    $display("FAIL burst_tm i=%0d owner=%b tmn=%b grn=%b addr=%h want 01/1/0/00100",
                             i, owner, tm_next, gr_next, dram_addr);
                end
            end else begin
                if (owner !== OWN_GR || tm_next !== 1'b0 || gr_next !== 1'b1 || dram_addr !== 21'h1F000) begin
                    n_errors++;
                    $display("FAIL burst_gr i=%0d owner=%b tmn=%b grn=%b addr=%h want 10/0/1/1f000",
                             i, owner, tm_next, gr_next, dram_addr);
                end
            end
        end
        step();
        tm_req = 1'b0; gr_req = 1'b0; dram_next = 1'b0;
        #1;
        n_checks++;
        if (owner !== OWN_TM || dram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL burst_backtm owner=%b req=%b want 01/0", owner, dram_req);
        end
        step();
        tm_req = 1'b1; gr_req = 1'b1;
        step();
        #1;
`ifdef TS_ARB_RR_EN
        exp_tie = OWN_GR;
`else
        exp_tie = OWN_TM;
`endif
        n_checks++;
        if (owner !== exp_tie) begin
            n_errors++;
            $display("FAIL second_tie owner=%b want %b", owner, exp_tie);
        end
        tm_req = 1'b0; gr_req = 1'b0;
        step();
        #1;
        n_checks++;
        if (owner !== OWN_NONE) begin
            n_errors++;
            $display("FAIL tie_release owner=%b want 00", owner);
        end
    endtask

    task automatic test_req_drop();
        gr_req = 1'b1; gr_addr = 21'h0ABCD;
        step();
        dram_next = 1'b1;
        step();
        step();
        gr_req = 1'b0;
        #1;
        n_checks++;
        if (gr_next !== 1'b1 || tm_next !== 1'b0 || dram_req !== 1'b0 || dram_addr !== 21'h0ABCD) begin
            n_errors++;
            $display("FAIL drop_same grn=%b tmn=%b req=%b addr=%h want 1/0/0/0abcd",
                     gr_next, tm_next, dram_req, dram_addr);
        end
        step();
        dram_next = 1'b0;
        #1;
        n_checks++;
        if (owner !== OWN_NONE || dram_req !== 1'b0 || dut.r_wcnt !== 8'd3) begin
            n_errors++;
            $display("FAIL drop_after owner=%b req=%b wcnt=%0d want 00/0/3", owner, dram_req, dut.r_wcnt);
        end
    endtask

    task automatic test_start_mid();
        tm_req = 1'b1; tm_addr = 21'h12345;
        step();
        dram_next = 1'b1;
        step();
        step();
        step();
        start = 1'b1; gr_req = 1'b1;
        #1;
        n_checks++;
        if (tm_next !== 1'b1 || gr_next !== 1'b0 || dut.r_wcnt !== 8'd3) begin
            n_errors++;
            $display("FAIL start_same tmn=%b grn=%b wcnt=%0d want 1/0/3", tm_next, gr_next, dut.r_wcnt);
        end
        step();
        start = 1'b0; dram_next = 1'b0;
        #1;
        n_checks++;
        if (owner !== OWN_NONE || dut.r_wcnt !== 8'd0 || tm_next !== 1'b0) begin
            n_errors++;
            $display("FAIL start_after owner=%b wcnt=%0d tmn=%b want 00/0/0", owner, dut.r_wcnt, tm_next);
        end
        step();
        #1;
        n_checks++;
        if (owner !== OWN_TM || dram_addr !== 21'h12345) begin
            n_errors++;
            $display("FAIL start_tie owner=%b addr=%h want 01/12345", owner, dram_addr);
        end
        tm_req = 1'b0; gr_req = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        gr_req = 1'b1; gr_addr = 21'h1F0F0;
        step();
        dram_next = 1'b1;
        #1;
        n_checks++;
        if (owner !== OWN_GR || gr_next !== 1'b1 || dram_req !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_pre owner=%b grn=%b req=%b want 10/1/1", owner, gr_next, dram_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dram_req !== 1'b0 || gr_next !== 1'b0 || owner !== OWN_NONE || dram_addr !== 21'h0) begin
            n_errors++;
            $display("FAIL arst_now req=%b grn=%b owner=%b addr=%h want 0/0/00/0",
                     dram_req, gr_next, owner, dram_addr);
        end
        gr_req = 1'b0; dram_next = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (owner !== OWN_NONE || dram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_after owner=%b req=%b want 00/0", owner, dram_req);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_cap();
        test_req_drop();
        test_start_mid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
